// File: rtl/pipe_commit_monitor.sv
// Follows one issued token through NUM_PIPES stall-aware pipelines, NUM_STAGES stages deep.
// Latency: commit NUM_STAGES cycles after start, plus one per stall cycle. No backpressure; stall/flush are observed only.
module pipe_commit_monitor #(
   parameter int NUM_PIPES  = 2,
   parameter int NUM_STAGES = 4,
   parameter int CNT_W      = 8,
   parameter int CNT_SAT    = 132,
   parameter int MAX_CYCLES = 50
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                issue,
   input  logic [NUM_PIPES-1:0]                valid_s1,
   input  logic [NUM_PIPES*NUM_STAGES-1:0]     stall,
   input  logic [NUM_PIPES-1:0]                flush,
   input  logic [NUM_PIPES-1:0]                end_mask,
   output logic                                start,
   output logic                                started,
   output logic [CNT_W-1:0]                    cycle_cnt,
   output logic [NUM_PIPES*(NUM_STAGES-1)-1:0] stage_tok,
   output logic [NUM_PIPES-1:0]                commit,
   output logic                                iend,
   output logic                                ended,
   output logic                                second_end,
   output logic                                timeout
);

   localparam logic [CNT_W-1:0] SAT_V = CNT_W'(CNT_SAT);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CYCLES);

   logic [NUM_PIPES-1:0][NUM_STAGES-1:1] tok;
   logic [NUM_PIPES-1:0][NUM_STAGES-1:0] adv;
   logic                                 ev;

   always_comb begin
      adv       = '0;
      stage_tok = '0;
      for (int p = 0; p < NUM_PIPES; p++) begin
         adv[p][0] = start & valid_s1[p] & ~stall[p*NUM_STAGES];
         for (int k = 1; k < NUM_STAGES; k++) begin
            adv[p][k] = tok[p][k] & ~stall[p*NUM_STAGES+k];
            stage_tok[p*(NUM_STAGES-1)+k-1] = tok[p][k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok    <= '0;
         commit <= '0;
      end else begin
         for (int p = 0; p < NUM_PIPES; p++) begin
            // flush wins over both load and hold, including a token arriving this cycle
            if (flush[p]) begin
               tok[p]    <= '0;
               commit[p] <= 1'b0;
            end else begin
               commit[p] <= adv[p][NUM_STAGES-1];
               for (int k = 1; k < NUM_STAGES; k++) begin
                  if (!stall[p*NUM_STAGES+k])
                     tok[p][k] <= adv[p][k-1];
               end
            end
         end
      end
   end

   assign ev   = |(commit & end_mask);
   assign iend = ev & started & ~ended & (cycle_cnt <= MAX_V);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start      <= 1'b0;
         started    <= 1'b0;
         cycle_cnt  <= '0;
         ended      <= 1'b0;
         second_end <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         // single pulse per run: once started, later issues are ignored
         start <= issue & ~start & ~started;
         if (start)
            started <= 1'b1;
         if ((start | started) && (cycle_cnt < SAT_V))
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         if (iend)
            ended <= 1'b1;
         if (ended & ev & ~second_end)
            second_end <= 1'b1;
         if (started & ~ended & (cycle_cnt > MAX_V))
            timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_commit_monitor.sv
// Randomized bench for pipe_commit_monitor against a token-position reference model.
module tb_pipe_commit_monitor;

   localparam int NP  = 2;
   localparam int NS  = 4;
   localparam int SAT = 132;
   localparam int MAXC = 50;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 issue;
   logic [NP-1:0]        valid_s1;
   logic [NP*NS-1:0]     stall;
   logic [NP-1:0]        flush;
   logic [NP-1:0]        end_mask;
   logic                 start, started, iend, ended, second_end, timeout;
   logic [7:0]           cycle_cnt;
   logic [NP*(NS-1)-1:0] stage_tok;
   logic [NP-1:0]        commit;

   pipe_commit_monitor dut (
      .clk(clk), .rst_n(rst_n), .issue(issue), .valid_s1(valid_s1), .stall(stall),
      .flush(flush), .end_mask(end_mask), .start(start), .started(started),
      .cycle_cnt(cycle_cnt), .stage_tok(stage_tok), .commit(commit), .iend(iend),
      .ended(ended), .second_end(second_end), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference: each pipe holds at most one token, tracked by its stage index (0 = none).
   bit      m_start, m_started, m_ended, m_second, m_timeout;
   int      m_cnt;
   int      m_pos [NP];
   bit      m_commit [NP];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_start = 0; m_started = 0; m_ended = 0; m_second = 0; m_timeout = 0; m_cnt = 0;
      for (int p = 0; p < NP; p++) begin
         m_pos[p] = 0;
         m_commit[p] = 0;
      end
   endtask

   function automatic bit model_ev();
      bit e = 0;
      for (int p = 0; p < NP; p++) e |= m_commit[p] & end_mask[p];
      return e;
   endfunction

   function automatic bit model_iend();
      return model_ev() && m_started && !m_ended && (m_cnt <= MAXC);
   endfunction

   task automatic check_all();
      logic [NP*(NS-1)-1:0] exp_tok;
      logic [NP-1:0]        exp_commit;
      exp_tok = '0;
      for (int p = 0; p < NP; p++) begin
         exp_commit[p] = m_commit[p];
         if (m_pos[p] != 0) exp_tok[p*(NS-1)+m_pos[p]-1] = 1'b1;
      end
      check_eq("start", 32'(start), 32'(m_start));
      check_eq("started", 32'(started), 32'(m_started));
      check_eq("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
      check_eq("stage_tok", 32'(stage_tok), 32'(exp_tok));
      check_eq("commit", 32'(commit), 32'(exp_commit));
      check_eq("iend", 32'(iend), 32'(model_iend()));
      check_eq("ended", 32'(ended), 32'(m_ended));
      check_eq("second_end", 32'(second_end), 32'(m_second));
      check_eq("timeout", 32'(timeout), 32'(m_timeout));
   endtask

   task automatic model_step();
      bit ev, ie, n_start;
      int np;
      ev = model_ev();
      ie = model_iend();
      n_start = !(m_start || m_started) && issue;
      for (int p = 0; p < NP; p++) begin
         np = m_pos[p];
         m_commit[p] = 0;
         if (flush[p]) begin
            np = 0;
         end else if (m_pos[p] == 0) begin
            // a token moving into a stalled stage is not captured
            if (m_start && valid_s1[p] && !stall[p*NS]) np = stall[p*NS+1] ? 0 : 1;
         end else if (!stall[p*NS+m_pos[p]]) begin
            if (m_pos[p] == NS-1) begin
               m_commit[p] = 1;
               np = 0;
            end else begin
               np = stall[p*NS+m_pos[p]+1] ? 0 : m_pos[p] + 1;
            end
         end
         m_pos[p] = np;
      end
      if (m_ended && ev) m_second = 1;
      if (m_started && !m_ended && m_cnt > MAXC) m_timeout = 1;
      if (ie) m_ended = 1;
      if ((m_start || m_started) && m_cnt < SAT) m_cnt++;
      if (m_start) m_started = 1;
      m_start = n_start;
   endtask

   // One run: sync reset-release, then ncyc cycles of random inputs.
   task automatic run(input int ncyc, input int issue_pct, input int stall_pct,
                      input int flush_pct, input int rst_at);
      rst_n = 1'b0;
      issue = 0; valid_s1 = '0; stall = '0; flush = '0; end_mask = '0;
      model_reset();
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         issue    = (c == 0) || ($urandom_range(99) < issue_pct);
         valid_s1 = NP'($urandom_range((1 << NP) - 1));
         end_mask = NP'($urandom_range((1 << NP) - 1));
         for (int b = 0; b < NP*NS; b++) stall[b] = ($urandom_range(99) < stall_pct);
         for (int p = 0; p < NP; p++) flush[p] = ($urandom_range(99) < flush_pct);
         #1;
         check_all();
         if (c == rst_at) begin
            #1 rst_n = 1'b0;
            #1 model_reset();
            check_all();
            #1 rst_n = 1'b1;
         end
         model_step();
         @(posedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      issue = 0; valid_s1 = '0; stall = '0; flush = '0; end_mask = '0;
      model_reset();
      #3;
      check_all();
      run(20, 0, 0, 0, -1);
      run(40, 10, 15, 0, -1);
      run(70, 20, 25, 6, -1);
      run(40, 0, 10, 0, 4);
      run(160, 100, 5, 2, -1);
      run(150, 30, 40, 10, 60);
      for (int r = 0; r < 6; r++) run(60, 20, 15, 3, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_commit_monitor.md
Name: pipe_commit_monitor

Overview:
- Parametrised instruction-tracking monitor for L2 refinement-check wrappers.
- Generalises the fixed per-pipe S1..S4 monitor chains to NUM_PIPES pipelines of NUM_STAGES stages each.
- Each pipe follows a single issued token through stall-aware stages and produces a commit pulse.
- Also generates start/started/end/timeout bookkeeping, and adds per-pipe flush and a selectable end-condition mask.

Parameters:
NUM_PIPES, 2, number of independent pipelines tracked
NUM_STAGES, 4, stages per pipeline (>=2); stage 0 is the issue stage S1
CNT_W, 8, cycle counter width
CNT_SAT, 132, counter saturation value
MAX_CYCLES, 50, latest cycle count at which an end event is accepted

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
issue  in  1  request to start tracking
valid_s1  in  NUM_PIPES  per-pipe stage-0 valid
stall  in  NUM_PIPES*NUM_STAGES  stall of pipe p, stage k at bit p*NUM_STAGES+k
flush  in  NUM_PIPES  per-pipe token kill
end_mask  in  NUM_PIPES  pipes whose commit counts as the end event
start  out  1  one-cycle start pulse
started  out  1  sticky, tracking in progress
cycle_cnt  out  CNT_W  cycles since start, saturating
stage_tok  out  NUM_PIPES*(NUM_STAGES-1)  registered token flags for stages 1..NUM_STAGES-1
commit  out  NUM_PIPES  per-pipe registered commit pulse
iend  out  1  combinational first-end event
ended  out  1  sticky, first end seen
second_end  out  1  sticky, a further end event after ended
timeout  out  1  sticky, end not reached by MAX_CYCLES

Behaviour:
- Reset value of every output register is 0: start, started, cycle_cnt, stage_tok, commit, ended, second_end, timeout.
- Reset is asynchronous on rst_n low; all state clears immediately regardless of activity mid-flight.
- start:
  - cleared when start or started is high;
  - otherwise set when issue is high;
  - so it is a single pulse for the whole run, and a later issue is ignored.
- started: set on the cycle after start; sticky.
- cycle_cnt:
  - increments when (start | started) and cycle_cnt < CNT_SAT;
  - holds at CNT_SAT and never wraps.
- Stage 0 token (combinational): adv0[p] = start & valid_s1[p] & ~stall[p,0].
- Stage k, 1 <= k < NUM_STAGES:
  - tok[p,k] loads adv(k-1)[p] when ~stall[p,k], and holds when stall[p,k] is high;
  - adv(k)[p] = tok[p,k] & ~stall[p,k].
- commit[p] is registered every cycle: commit[p] <= adv(NUM_STAGES-1)[p].
- flush[p] clears all tok[p,*] and commit[p] on the next edge, with priority over load and hold. A token arriving in the flush cycle is also dropped.
- Latency: with no stalls, a start in cycle t gives commit in cycle t+NUM_STAGES. Each stall cycle on the token's current stage adds one cycle.
- Pipes are fully independent; simultaneous commits on several pipes are legal.
- Define ev = |(commit & end_mask).
- iend = ev & started & ~ended & (cycle_cnt <= MAX_CYCLES).
- ended is set on iend.
- second_end is set when ended & ev & ~second_end. A commit in the same cycle as iend does not count as a second end.
- timeout is set when started & ~ended & (cycle_cnt > MAX_CYCLES). Once timeout is set, iend is blocked because the counter condition fails.
- end_mask = 0: no end ever occurs; timeout follows after MAX_CYCLES.
- Inputs have no effect on pipe tracking before start. Token stages only hold the single start-cycle token.

Test Plan:
- Defaults, issue=1 at cycle 0, valid_s1=2'b01, no stalls, end_mask=01 -> start at cycle 1; commit[0] at cycle 5; iend=1 at cycle 5 with cycle_cnt=4; ended=1 from cycle 6; timeout stays 0.
- As above, but stall[0,2] held 3 cycles while the token sits in stage 2 -> commit[0] delayed to cycle 8; stage_tok bit for pipe 0, stage 2 holds during those 3 cycles.
- Both pipes valid, end_mask=11, pipe 1 stalled 2 cycles -> iend on pipe 0 commit (cycle 5); pipe 1 commit at cycle 7 sets second_end.
- flush[0] asserted while the token is in stage 1 -> no commit[0]; with end_mask=01, timeout sets when cycle_cnt reaches 51; cycle_cnt saturates at 132.
- rst_n pulsed low asynchronously mid-run (token in stage 2) -> all outputs 0 immediately; after release, a new issue restarts with the same latency.
- issue held high continuously -> start pulses exactly once; cycle_cnt reaches 132 and stays.
